// File: rtl/gs_sample_packer.sv
// gs_sample_packer: packs 16-bit GS raw samples into 32-bit words framed by
// a header (tag, test ID) and a trailer (tag, test ID, accepted-sample count),
// buffered in a small circular queue ahead of the host FIFO.
module gs_sample_packer #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [7:0]  HDR_TAG = 8'hA5,
  parameter logic [7:0]  TRL_TAG = 8'h5A
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic [7:0]  i8TestId,
  input  logic        iSampleValid,
  input  logic [15:0] i16Sample,
  input  logic        iEndTest,
  input  logic        iFifoFull,
  output logic        oWrEn,
  output logic [31:0] o32Data,
  output logic        oBusy,
  output logic        oOverflow,
  output logic [15:0] o16Count
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned SMP_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH,
    TRAILER
  } state_t;

  state_t             state;
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic [SMP_W-1:0]   hold;
  logic               hold_full;
  logic [7:0]         test_id;
  logic [SMP_W-1:0]   count;
  logic               overflow;

  logic               pop;
  logic               room;
  logic               push;
  logic [WORD_W-1:0]  push_data;
  logic [WORD_W-1:0]  trailer_word;

  // Queue handshake: a pop frees its entry before a same-cycle push needs it.
  always_comb begin
    pop          = (occ != '0) && !iFifoFull;
    room         = (occ != OCC_W'(DEPTH)) || pop;
    trailer_word = {TRL_TAG, test_id, count};
  end

  // Which word (if any) the current state wants to enqueue this cycle.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    unique case (state)
      IDLE: begin
        if (iStart && room) begin
          push      = 1'b1;
          push_data = {HDR_TAG, i8TestId, 16'h0000};
        end
      end
      COLLECT: begin
        if (iSampleValid && hold_full && room) begin
          push      = 1'b1;
          push_data = {hold, i16Sample};
        end
      end
      FLUSH: begin
        if (room) begin
          push      = 1'b1;
          push_data = hold_full ? {hold, 16'h0000} : trailer_word;
        end
      end
      TRAILER: begin
        if (room) begin
          push      = 1'b1;
          push_data = trailer_word;
        end
      end
      default: begin
        push      = 1'b0;
        push_data = '0;
      end
    endcase
  end

  // Queue storage; contents need no reset since the head is gated by occupancy.
  always_ff @(posedge iClk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Frame FSM plus queue pointers, occupancy, hold register and counters.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      test_id   <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      occ <= occ + OCC_W'(push) - OCC_W'(pop);

      unique case (state)
        IDLE: begin
          if (push) begin
            test_id   <= i8TestId;
            count     <= '0;
            overflow  <= 1'b0;
            hold_full <= 1'b0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          if (iSampleValid) begin
            if (!hold_full) begin
              hold      <= i16Sample;
              hold_full <= 1'b1;
              count     <= (count == 16'hFFFF) ? count : count + 16'd1;
            end else if (push) begin
              hold_full <= 1'b0;
              count     <= (count == 16'hFFFF) ? count : count + 16'd1;
            end else begin
              overflow <= 1'b1;
            end
          end
          if (iEndTest) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (iSampleValid) begin
            overflow <= 1'b1;
          end
          if (push) begin
            if (hold_full) begin
              hold_full <= 1'b0;
              state     <= TRAILER;
            end else begin
              state <= IDLE;
            end
          end
        end
        TRAILER: begin
          if (iSampleValid) begin
            overflow <= 1'b1;
          end
          if (push) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output view of the queue head and frame status.
  always_comb begin
    oWrEn     = pop;
    o32Data   = (occ != '0) ? mem[rd_ptr] : '0;
    oBusy     = (state != IDLE) || (occ != '0);
    oOverflow = overflow;
    o16Count  = count;
  end

endmodule
